// File: rtl/hci_parity_fault_ctrl_pkg.sv
// Shared types and width helpers for the HCI parity fault controller.
package hci_package;

  // Controller states: collecting (ARMED), latched alarm (ALARM), one-cycle clear (CLEAR).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALARM = 2'd2,
    CLEAR = 2'd3
  } hci_parity_fault_state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold a population count of n bits (0..n).
  function automatic int unsigned pop_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hci_parity_fault_ctrl_prio.sv
// Lowest-index priority encoder plus popcount over an N_CH-bit fault vector.
// Purely combinational so per-cluster aggregators can reuse it.
module hci_parity_fault_prio
  import hci_package::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = idx_width(N_CH),
  parameter int unsigned PC_W  = pop_width(N_CH)
) (
  input  logic [N_CH-1:0]  vec_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [PC_W-1:0]  pop_o
);

  // Scan from the top down so the last hit written is the lowest set index.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

  // Count the set bits of the vector.
  always_comb begin
    pop_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_o = pop_o + PC_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/hci_parity_fault_ctrl.sv
// Central fault controller: masks and counts parity faults, captures the first
// faulting channel, raises a level alarm with a one-cycle irq, and runs the
// clear handshake. All outputs come straight from flops.
module hci_parity_fault_ctrl
  import hci_package::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned IDX_W = idx_width(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [N_CH-1:0]  fault_i,
  input  logic [N_CH-1:0]  mask_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic             clear_req_i,
  output logic             clear_ack_o,
  output logic             alarm_o,
  output logic             irq_o,
  output logic [N_CH-1:0]  status_o,
  output logic             first_valid_o,
  output logic [IDX_W-1:0] first_ch_o,
  output logic [CNT_W-1:0] fault_cnt_o
);

  localparam int unsigned PC_W  = pop_width(N_CH);
  // Sum wide enough that count + popcount can never wrap before saturation.
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hci_parity_fault_state_t state_q, state_d;

  logic             alarm_q, irq_q, ack_q;
  logic [N_CH-1:0]  status_q;
  logic             first_valid_q;
  logic [IDX_W-1:0] first_ch_q;
  logic [CNT_W-1:0] fault_cnt_q;

  logic [N_CH-1:0]  eff;
  logic             eff_any;
  logic [IDX_W-1:0] eff_idx;
  logic [PC_W-1:0]  eff_pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] thr_eff;
  logic             alarm_hit;

  // Faults only count while collecting; in IDLE and CLEAR they are dropped.
  always_comb begin
    eff = '0;
    if (state_q == ARMED || state_q == ALARM) begin
      eff = fault_i & ~mask_i;
    end
  end

  hci_parity_fault_prio #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W),
    .PC_W  (PC_W)
  ) u_prio (
    .vec_i (eff),
    .any_o (eff_any),
    .idx_o (eff_idx),
    .pop_o (eff_pop)
  );

  // Saturating count and threshold compare; alarm only fires on a cycle with a
  // new fault, so lowering the threshold never raises a retroactive alarm.
  always_comb begin
    cnt_sum   = SUM_W'(fault_cnt_q) + SUM_W'(eff_pop);
    cnt_next  = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    thr_eff   = (threshold_i == '0) ? CNT_W'(1) : threshold_i;
    alarm_hit = eff_any && (cnt_next >= thr_eff);
  end

  // Next-state logic: clear wins over everything; a new alarm wins over disable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i)   state_d = CLEAR;
        else if (enable_i) state_d = ARMED;
      end
      ARMED: begin
        if (clear_req_i)    state_d = CLEAR;
        else if (alarm_hit) state_d = ALARM;
        else if (!enable_i) state_d = IDLE;
      end
      ALARM: begin
        if (clear_req_i) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = enable_i ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flag and counter registers; entering CLEAR zeroes the captured data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      alarm_q       <= 1'b0;
      irq_q         <= 1'b0;
      ack_q         <= 1'b0;
      status_q      <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      fault_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alarm_q <= (state_d == ALARM);
      irq_q   <= (state_d == ALARM) && (state_q != ALARM);
      ack_q   <= (state_d == CLEAR);
      if (state_d == CLEAR) begin
        status_q      <= '0;
        first_valid_q <= 1'b0;
        first_ch_q    <= '0;
        fault_cnt_q   <= '0;
      end else begin
        status_q    <= status_q | eff;
        fault_cnt_q <= cnt_next;
        if (!first_valid_q && eff_any) begin
          first_valid_q <= 1'b1;
          first_ch_q    <= eff_idx;
        end
      end
    end
  end

  assign clear_ack_o   = ack_q;
  assign alarm_o       = alarm_q;
  assign irq_o         = irq_q;
  assign status_o      = status_q;
  assign first_valid_o = first_valid_q;
  assign first_ch_o    = first_ch_q;
  assign fault_cnt_o   = fault_cnt_q;

endmodule

// File: tb/tb_hci_parity_fault_ctrl.sv
// Bench for hci_parity_fault_ctrl: directed vector table, saturation run and
// randomized traffic compared against a behavioural model.
module tb_hci_parity_fault_ctrl;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_ALARM = 2;
  localparam int M_CLEAR = 3;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             enable_i;
  logic [N_CH-1:0]  fault_i;
  logic [N_CH-1:0]  mask_i;
  logic [CNT_W-1:0] threshold_i;
  logic             clear_req_i;
  logic             clear_ack_o;
  logic             alarm_o;
  logic             irq_o;
  logic [N_CH-1:0]  status_o;
  logic             first_valid_o;
  logic [1:0]       first_ch_o;
  logic [CNT_W-1:0] fault_cnt_o;

  int tests = 0;
  int fails = 0;

  hci_parity_fault_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .fault_i       (fault_i),
    .mask_i        (mask_i),
    .threshold_i   (threshold_i),
    .clear_req_i   (clear_req_i),
    .clear_ack_o   (clear_ack_o),
    .alarm_o       (alarm_o),
    .irq_o         (irq_o),
    .status_o      (status_o),
    .first_valid_o (first_valid_o),
    .first_ch_o    (first_ch_o),
    .fault_cnt_o   (fault_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] f;
    logic [3:0] m;
    logic [7:0] thr;
    logic       clr;
    logic       alarm;
    logic       irq;
    logic       ack;
    logic [3:0] st;
    logic       fv;
    logic [1:0] fc;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[28];

  // Behavioural model state
  int         m_mode;
  int         m_cnt;
  logic [3:0] m_st;
  logic       m_fv;
  int         m_fc;
  logic       m_alarm, m_irq, m_ack;

  function automatic vec_t mk(logic r, logic e, logic [3:0] f, logic [3:0] m,
                              logic [7:0] t, logic c, logic a, logic i, logic k,
                              logic [3:0] s, logic v, logic [1:0] fc, logic [7:0] n);
    vec_t x;
    x.rst_n = r; x.en = e; x.f = f; x.m = m; x.thr = t; x.clr = c;
    x.alarm = a; x.irq = i; x.ack = k; x.st = s; x.fv = v; x.fc = fc; x.cnt = n;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, derived from the controller's behavioural rules.
  task automatic model_step();
    logic [3:0] e;
    int pc, nc, thr, nm;
    if (!rst_ni) begin
      m_mode = M_IDLE; m_cnt = 0; m_st = 0; m_fv = 0; m_fc = 0;
      m_alarm = 0; m_irq = 0; m_ack = 0;
      return;
    end
    e   = (m_mode == M_ARMED || m_mode == M_ALARM) ? (fault_i & ~mask_i) : 4'b0;
    pc  = $countones(e);
    nc  = (m_cnt + pc > 255) ? 255 : m_cnt + pc;
    thr = (threshold_i == 0) ? 1 : int'(threshold_i);
    nm  = m_mode;
    if (clear_req_i && m_mode != M_CLEAR) nm = M_CLEAR;
    else if (m_mode == M_IDLE && enable_i) nm = M_ARMED;
    else if (m_mode == M_ARMED && pc > 0 && nc >= thr) nm = M_ALARM;
    else if (m_mode == M_ARMED && !enable_i) nm = M_IDLE;
    else if (m_mode == M_CLEAR) nm = enable_i ? M_ARMED : M_IDLE;
    m_irq   = (nm == M_ALARM) && (m_mode != M_ALARM);
    m_alarm = (nm == M_ALARM);
    m_ack   = (nm == M_CLEAR);
    if (nm == M_CLEAR) begin
      m_st = 0; m_cnt = 0; m_fv = 0; m_fc = 0;
    end else begin
      m_st  = m_st | e;
      m_cnt = nc;
      if (!m_fv && e != 0) begin
        m_fv = 1;
        for (int i = 3; i >= 0; i--) if (e[i]) m_fc = i;
      end
    end
    m_mode = nm;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " alarm"},  alarm_o,       m_alarm);
    chk({tag, " irq"},    irq_o,         m_irq);
    chk({tag, " ack"},    clear_ack_o,   m_ack);
    chk({tag, " status"}, status_o,      m_st);
    chk({tag, " fvalid"}, first_valid_o, m_fv);
    chk({tag, " firstch"},first_ch_o,    m_fc);
    chk({tag, " count"},  fault_cnt_o,   m_cnt);
  endtask

  int irq_seen;
  int exp_cnt;

  initial begin
    rst_ni = 0; enable_i = 0; fault_i = 0; mask_i = 0; threshold_i = 0; clear_req_i = 0;

    //            rst en f       m       thr  clr  alarm irq ack st      fv fc  cnt
    tbl[0]  = mk(0, 1, 4'b0000, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(1, 1, 4'b0000, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(1, 1, 4'b0000, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[3]  = mk(1, 1, 4'b0000, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[4]  = mk(1, 1, 4'b0010, 4'b0000, 3, 0,   0, 0, 0, 4'b0010, 1, 1, 1);
    tbl[5]  = mk(1, 1, 4'b0101, 4'b0000, 3, 0,   1, 1, 0, 4'b0111, 1, 1, 3);
    tbl[6]  = mk(1, 1, 4'b0000, 4'b0000, 3, 0,   1, 0, 0, 4'b0111, 1, 1, 3);
    tbl[7]  = mk(1, 0, 4'b0000, 4'b0000, 3, 0,   1, 0, 0, 4'b0111, 1, 1, 3);
    tbl[8]  = mk(1, 1, 4'b0001, 4'b0000, 3, 1,   0, 0, 1, 4'b0000, 0, 0, 0);
    tbl[9]  = mk(1, 1, 4'b0001, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[10] = mk(1, 1, 4'b0001, 4'b0000, 3, 0,   0, 0, 0, 4'b0001, 1, 0, 1);
    tbl[11] = mk(1, 1, 4'b0000, 4'b0000, 3, 1,   0, 0, 1, 4'b0000, 0, 0, 0);
    tbl[12] = mk(1, 1, 4'b1001, 4'b0001, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[13] = mk(1, 1, 4'b1001, 4'b0001, 3, 0,   0, 0, 0, 4'b1000, 1, 3, 1);
    tbl[14] = mk(1, 1, 4'b0001, 4'b0000, 3, 0,   0, 0, 0, 4'b1001, 1, 3, 2);
    tbl[15] = mk(1, 1, 4'b0001, 4'b0000, 3, 0,   1, 1, 0, 4'b1001, 1, 3, 3);
    tbl[16] = mk(0, 1, 4'b1111, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[17] = mk(1, 0, 4'b1111, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[18] = mk(1, 0, 4'b1111, 4'b0000, 3, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[19] = mk(1, 1, 4'b0000, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[20] = mk(1, 1, 4'b0100, 4'b0000, 0, 0,   1, 1, 0, 4'b0100, 1, 2, 1);
    tbl[21] = mk(1, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 1, 4'b0000, 0, 0, 0);
    tbl[22] = mk(1, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[23] = mk(1, 1, 4'b0000, 4'b0000, 0, 1,   0, 0, 1, 4'b0000, 0, 0, 0);
    tbl[24] = mk(1, 1, 4'b0000, 4'b0000, 5, 0,   0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[25] = mk(1, 1, 4'b0011, 4'b0000, 5, 0,   0, 0, 0, 4'b0011, 1, 0, 2);
    tbl[26] = mk(1, 1, 4'b0000, 4'b0000, 1, 0,   0, 0, 0, 4'b0011, 1, 0, 2);
    tbl[27] = mk(1, 1, 4'b1000, 4'b0000, 1, 0,   1, 1, 0, 4'b1011, 1, 0, 3);

    // Directed vector table
    #1;
    for (int v = 0; v < 28; v++) begin
      rst_ni = tbl[v].rst_n; enable_i = tbl[v].en; fault_i = tbl[v].f;
      mask_i = tbl[v].m; threshold_i = tbl[v].thr; clear_req_i = tbl[v].clr;
      step();
      $display("[TB] vec %0d: ack=%0d alarm=%0d irq=%0d status=%b first=%0d/%0d cnt=%0d",
               v, clear_ack_o, alarm_o, irq_o, status_o, first_valid_o, first_ch_o, fault_cnt_o);
      chk($sformatf("vec%0d alarm", v),   alarm_o,       tbl[v].alarm);
      chk($sformatf("vec%0d irq", v),     irq_o,         tbl[v].irq);
      chk($sformatf("vec%0d ack", v),     clear_ack_o,   tbl[v].ack);
      chk($sformatf("vec%0d status", v),  status_o,      tbl[v].st);
      chk($sformatf("vec%0d fvalid", v),  first_valid_o, tbl[v].fv);
      chk($sformatf("vec%0d firstch", v), first_ch_o,    tbl[v].fc);
      chk($sformatf("vec%0d count", v),   fault_cnt_o,   tbl[v].cnt);
    end

    // Saturation: four faults per cycle against threshold 255
    rst_ni = 0; enable_i = 1; fault_i = 0; mask_i = 0; threshold_i = 255; clear_req_i = 0;
    step();
    rst_ni = 1;
    step();
    irq_seen = 0;
    fault_i = 4'b1111;
    for (int k = 1; k <= 70; k++) begin
      step();
      exp_cnt = (4 * k > 255) ? 255 : 4 * k;
      chk($sformatf("sat count k=%0d", k), fault_cnt_o, exp_cnt);
      if (irq_o) irq_seen++;
    end
    $display("[TB] saturation: cnt=%0d alarm=%0d irq pulses=%0d", fault_cnt_o, alarm_o, irq_seen);
    chk("sat final count", fault_cnt_o, 255);
    chk("sat irq pulses", irq_seen, 1);
    chk("sat alarm", alarm_o, 1);

    // Randomized traffic against the model
    rst_ni = 0; fault_i = 0; clear_req_i = 0;
    step();
    for (int c = 0; c < 3000; c++) begin
      rst_ni      = ($urandom_range(0, 99) != 0);
      enable_i    = ($urandom_range(0, 7) != 0);
      fault_i     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      mask_i      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      threshold_i = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
      clear_req_i = ($urandom_range(0, 23) == 0);
      step();
      check_model($sformatf("rnd%0d", c));
      if (c % 500 == 499)
        $display("[TB] random cycle %0d: cnt=%0d alarm=%0d status=%b", c, fault_cnt_o, alarm_o, status_o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
